// File: rtl/stopwatch_pkg.sv
// ============================================================================
//  Module      : stopwatch_pkg
//  Description : Shared types and constants for the stopwatch controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        ADJUST = 2'd3
    } state_t;

    localparam int         BCD_W     = 5;
    localparam logic [3:0] BLANK_MIN = 4'b1100;
    localparam logic [3:0] BLANK_SEC = 4'b0011;

    // Packs a 0..99 integer into two BCD nibbles {tens, ones}.
    function automatic logic [7:0] to_bcd8(input int value);
        return {4'(value / 10), 4'(value % 10)};
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd2_counter.sv
// ============================================================================
//  Module      : bcd2_counter
//  Description : Two-digit BCD counter with synchronous clear and wrap at max.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd2_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    input  logic [7:0] max_val,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       carry_out
);

    logic [3:0] r_tens;
    logic [3:0] r_ones;
    logic       w_at_max;

    // Compare at-or-above so an out-of-range value can never keep counting up.
    assign w_at_max  = ({r_tens, r_ones} >= max_val);
    assign carry_out = inc && w_at_max;
    assign tens      = r_tens;
    assign ones      = r_ones;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tens <= 4'd0;
            r_ones <= 4'd0;
        end else if (clr) begin
            r_tens <= 4'd0;
            r_ones <= 4'd0;
        end else if (inc) begin
            if (w_at_max) begin
                r_tens <= 4'd0;
                r_ones <= 4'd0;
            end else if (r_ones >= 4'd9) begin
                r_tens <= r_tens + 4'd1;
                r_ones <= 4'd0;
            end else begin
                r_ones <= r_ones + 4'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
// ============================================================================
//  Module      : stopwatch_ctrl
//  Description : MM:SS stopwatch sequencer with run/pause/clear/adjust control.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stopwatch_ctrl #(
    parameter int MAX_MIN = 59
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          tick_1hz,
    input  logic                          tick_adj,
    input  logic                          tick_blink,
    input  logic                          pause_p,
    input  logic                          clr_p,
    input  logic                          adj,
    input  logic                          sel,
    output logic [stopwatch_pkg::BCD_W-1:0] min_l,
    output logic [stopwatch_pkg::BCD_W-1:0] min_r,
    output logic [stopwatch_pkg::BCD_W-1:0] sec_l,
    output logic [stopwatch_pkg::BCD_W-1:0] sec_r,
    output logic [3:0]                    blank,
    output logic                          running,
    output logic                          wrap_p
);

    import stopwatch_pkg::*;

    localparam logic [7:0] c_MAX_SEC_BCD = 8'h59;
    localparam logic [7:0] c_MAX_MIN_BCD = to_bcd8(MAX_MIN);

    state_t     r_state;
    state_t     w_state_next;
    logic       r_phase;
    logic       w_phase_next;
    logic [3:0] r_blank;
    logic [3:0] w_blank_next;
    logic       r_wrap;

    logic       w_sec_inc;
    logic       w_min_inc;
    logic       w_sec_carry;
    logic       w_min_carry;
    logic [3:0] w_sec_tens;
    logic [3:0] w_sec_ones;
    logic [3:0] w_min_tens;
    logic [3:0] w_min_ones;

    // Seconds carry only ripples into minutes while running; adjust edits one field.
    assign w_sec_inc = ((r_state == RUN) && tick_1hz)
                    || ((r_state == ADJUST) && sel && tick_adj);
    assign w_min_inc = ((r_state == RUN) && w_sec_carry)
                    || ((r_state == ADJUST) && !sel && tick_adj);

    bcd2_counter u_sec (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr_p),
        .inc       (w_sec_inc),
        .max_val   (c_MAX_SEC_BCD),
        .tens      (w_sec_tens),
        .ones      (w_sec_ones),
        .carry_out (w_sec_carry)
    );

    bcd2_counter u_min (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr_p),
        .inc       (w_min_inc),
        .max_val   (c_MAX_MIN_BCD),
        .tens      (w_min_tens),
        .ones      (w_min_ones),
        .carry_out (w_min_carry)
    );

    always_comb begin
        w_state_next = r_state;
        if (clr_p) begin
            w_state_next = adj ? ADJUST : IDLE;
        end else if (adj) begin
            w_state_next = ADJUST;
        end else begin
            case (r_state)
                IDLE:    if (pause_p) w_state_next = RUN;
                RUN:     if (pause_p) w_state_next = PAUSED;
                PAUSED:  if (pause_p) w_state_next = RUN;
                ADJUST:  w_state_next = PAUSED;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Phase is held at zero outside ADJUST so every entry starts unblanked.
    always_comb begin
        w_phase_next = r_phase;
        w_blank_next = 4'b0000;
        if ((w_state_next != ADJUST) || (r_state != ADJUST)) begin
            w_phase_next = 1'b0;
        end else if (tick_blink) begin
            w_phase_next = ~r_phase;
        end
        if ((w_state_next == ADJUST) && w_phase_next) begin
            w_blank_next = sel ? BLANK_SEC : BLANK_MIN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_phase <= 1'b0;
            r_blank <= 4'b0000;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_phase <= w_phase_next;
            r_blank <= w_blank_next;
            r_wrap  <= (r_state == RUN) && w_min_carry && !clr_p;
        end
    end

    assign min_l   = {1'b0, w_min_tens};
    assign min_r   = {1'b0, w_min_ones};
    assign sec_l   = {1'b0, w_sec_tens};
    assign sec_r   = {1'b0, w_sec_ones};
    assign blank   = r_blank;
    assign running = (r_state == RUN);
    assign wrap_p  = r_wrap;

endmodule

`default_nettype wire

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Sequencing controller for the stopwatch MM:SS datapath. It owns the BCD time registers and the run/pause/clear/adjust state machine. It drives the four digit values (min_l, min_r, sec_l, sec_r) consumed by the display scanner, plus a per-panel blank mask used to blink the field being adjusted. It sits between the clock divider and debouncer outputs and the display block.

Parameters:
MAX_MIN, 59, highest minute value; the minutes field wraps from MAX_MIN to 00 (legal range 1..99).

Ports:
clk  in  1  system clock; all state updates on its rising edge.
rst_n  in  1  asynchronous active-low reset.
tick_1hz  in  1  one-cycle count-enable pulse, 1 Hz.
tick_adj  in  1  one-cycle adjust-increment pulse, 2 Hz.
tick_blink  in  1  one-cycle blink-phase toggle pulse, 4 Hz.
pause_p  in  1  debounced one-cycle pulse that toggles run/pause.
clr_p  in  1  debounced one-cycle pulse that clears the time.
adj  in  1  level; 1 selects adjust mode.
sel  in  1  level; adjust field select, 0 = minutes, 1 = seconds.
min_l, min_r, sec_l, sec_r  out  5 each  BCD digits 0-9; bit 4 is always 0.
blank  out  4  per-panel blank mask, bit order {min_l, min_r, sec_l, sec_r}; 1 = blank the panel.
running  out  1  1 while in RUN.
wrap_p  out  1  one-cycle pulse on a count rollover from MAX_MIN:59 to 00:00.

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - all digits 0, blank = 0, running = 0, wrap_p = 0.
  - state = IDLE, blink phase = 0.
- States: IDLE, RUN, PAUSED, ADJUST. All registered; outputs are direct register outputs with no combinational path from inputs.
- Transition priority, highest first:
  - clr_p: any state -> IDLE and time -> 00:00, in the same edge. If adj = 1 at that edge, the next state is ADJUST with the time cleared.
  - adj = 1: any state -> ADJUST.
  - In ADJUST with adj = 0: -> PAUSED.
  - pause_p: IDLE -> RUN, RUN -> PAUSED, PAUSED -> RUN. Ignored in ADJUST.
- Counting:
  - On tick_1hz, when the current state is RUN, seconds increment.
  - If pause_p and tick_1hz coincide in RUN, the increment is applied and the state moves to PAUSED.
  - If clr_p coincides with tick_1hz, clr_p wins and the result is 00:00.
  - sec_r 9 -> 0 carries into sec_l; sec_l:sec_r 59 -> 00 carries into minutes.
  - Minutes MAX_MIN -> 00. At MAX_MIN:59 the next tick gives 00:00, wrap_p = 1 for one cycle, and the state stays RUN.
- ADJUST:
  - On tick_adj, the selected field increments by 1 with wrap 59 -> 00 for seconds and MAX_MIN -> 00 for minutes.
  - There is no carry into the other field. tick_1hz is ignored.
  - A change of sel takes effect on the next tick_adj.
- Blink:
  - tick_blink toggles the blink phase only while in ADJUST. The phase resets to 0 on entry to ADJUST.
  - blank = phase ? (sel ? 4'b0011 : 4'b1100) : 4'b0000 in ADJUST, and 4'b0000 in every other state. blank is registered and shows one cycle of latency.
- Digit update latency: one clk edge after the qualifying tick. Digits hold otherwise.
- BCD invariant: each field is always a legal BCD value 00..59 (seconds) or 00..MAX_MIN (minutes). Illegal values cannot be reached.

Decomposition:
- Shared package stopwatch_pkg:
  - state enum {IDLE, RUN, PAUSED, ADJUST};
  - BCD digit width constant (5);
  - blank-mask constants BLANK_MIN = 4'b1100, BLANK_SEC = 4'b0011.
- One natural sub-module, bcd2_counter: a two-digit BCD counter with inc, carry_in-enable, max-value input, value outputs and carry_out. It is instantiated twice, for seconds (max 59) and minutes (max MAX_MIN).

Test Plan:
1. Reset, pause_p, then 10 tick_1hz -> running = 1, digits 00:10. Check the 00:09 -> 00:10 carry.
2. Preload 00:59 in RUN, one tick_1hz -> 01:00. Preload 59:59, one tick -> 00:00, wrap_p high exactly 1 cycle, state stays RUN.
3. RUN at 03:27, then pause_p coincident with tick_1hz -> 03:28, running = 0. Further 5 ticks -> still 03:28. pause_p plus 1 tick -> 03:29.
4. RUN at 12:34, assert clr_p -> next edge 00:00, state IDLE, running = 0. clr_p coincident with tick_1hz -> 00:00.
5. adj = 1, sel = 1, time 07:58, then 3 tick_adj -> 07:59, 07:00, 07:01 (seconds wrap, minutes unchanged). Blank toggles 4'b0011 / 4'b0000 on tick_blink. adj = 0 -> PAUSED, blank = 0.
6. rst_n driven low asynchronously mid-RUN at 45:12 (not aligned to clk) -> outputs immediately 00:00, blank = 0, running = 0. Release, then pause_p -> counting resumes from 00:00.
